// File: rtl/ring_pkg.sv
// Shared definitions for the gold ring gather agent: packet field
// positions, sticky error bit indices, agent FSM states and the
// minimal-route helper used to build packet headers.
package ring_pkg;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int SRC_MSB = 47;
    localparam int SRC_LSB = 32;

    localparam int ERR_TX_TIMEOUT = 0;
    localparam int ERR_MISSING    = 1;
    localparam int ERR_UNEXPECTED = 2;
    localparam int ERR_DUPLICATE  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Returns {dir, hop[7:0]}. dir 0 walks towards increasing ids; a tie
    // between both directions resolves to dir 0. Hop is thermometer coded.
    function automatic logic [8:0] ring_route(
        input logic [3:0] src,
        input logic [3:0] dst,
        input logic [4:0] n
    );
        logic [4:0] fwd;
        logic [4:0] bwd;
        logic [4:0] d;
        logic       dir;
        logic [8:0] ones;
        if (dst >= src)
            fwd = {1'b0, dst} - {1'b0, src};
        else
            fwd = {1'b0, dst} + n - {1'b0, src};
        bwd = n - fwd;
        if (fwd <= bwd) begin
            dir = 1'b0;
            d   = fwd;
        end else begin
            dir = 1'b1;
            d   = bwd;
        end
        ones = (9'd1 << d) - 9'd1;
        return {dir, ones[7:0]};
    endfunction

endpackage

// File: rtl/gather_rx_checker.sv
// Root-side delivery checker: tracks which sources delivered this phase,
// counts accepted packets and raises sticky missing/unexpected/duplicate.
// Ports: clk, reset; i_clear (sequence start), i_phase_end (last window
// cycle), i_busy, i_phase, i_round, i_valid/i_data (delivered packet);
// o_rx_total, o_err_miss, o_err_unexp, o_err_dup.
module gather_rx_checker
    import ring_pkg::*;
#(
    parameter int NUM_NODES = 4,
    parameter int NODE_ID   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_phase_end,
    input  logic        i_busy,
    input  logic [3:0]  i_phase,
    input  logic [7:0]  i_round,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    output logic [15:0] o_rx_total,
    output logic        o_err_miss,
    output logic        o_err_unexp,
    output logic        o_err_dup
);

    localparam logic [15:0] EXP_MASK = 16'(((32'd1 << NUM_NODES) - 32'd1)
                                           & ~(32'd1 << NODE_ID));

    logic [15:0] r_bitmap;
    logic [15:0] r_rx_total;
    logic        r_miss;
    logic        r_unexp;
    logic        r_dup;

    logic [15:0] w_src;
    logic [3:0]  w_pph;
    logic [7:0]  w_prd;
    logic        w_accept;
    logic [15:0] w_bit;
    logic        w_seen;
    logic        w_dup;
    logic        w_new;
    logic [15:0] w_bitmap_nxt;
    logic        w_unused_data;

    assign w_src = i_data[SRC_MSB:SRC_LSB];
    assign w_pph = i_data[3:0];
    assign w_prd = i_data[23:16];
    assign w_unused_data = ^{i_data[63:48], i_data[31:24], i_data[15:4]};

    assign w_accept = i_busy
                   && (w_pph == i_phase)
                   && (w_prd == i_round)
                   && (i_phase == 4'(NODE_ID))
                   && (w_src < 16'(NUM_NODES))
                   && (w_src != 16'(NODE_ID));

    assign w_bit  = 16'd1 << w_src[3:0];
    assign w_seen = |(r_bitmap & w_bit);
    assign w_dup  = i_valid && w_accept && w_seen;
    assign w_new  = i_valid && w_accept && !w_seen;

    // A delivery in the final window cycle must count toward completeness.
    assign w_bitmap_nxt = w_new ? (r_bitmap | w_bit) : r_bitmap;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_bitmap   <= '0;
            r_rx_total <= '0;
            r_miss     <= 1'b0;
            r_unexp    <= 1'b0;
            r_dup      <= 1'b0;
        end else begin
            if (i_valid && !w_accept)
                r_unexp <= 1'b1;
            if (w_dup)
                r_dup <= 1'b1;
            if (w_new && (r_rx_total != 16'hFFFF))
                r_rx_total <= r_rx_total + 16'd1;
            if (i_phase_end) begin
                if ((i_phase == 4'(NODE_ID))
                    && ((w_bitmap_nxt & EXP_MASK) != EXP_MASK))
                    r_miss <= 1'b1;
                r_bitmap <= '0;
            end else begin
                r_bitmap <= w_bitmap_nxt;
            end
        end
    end

    assign o_rx_total  = r_rx_total;
    assign o_err_miss  = r_miss;
    assign o_err_unexp = r_unexp;
    assign o_err_dup   = r_dup;

endmodule

// File: rtl/ring_gather_agent.sv
// Per-node all-to-root gather sequencer for the gold ring PE port.
// Ports: clk, reset, polarity, start; PE send pesi/pedi/peri; PE receive
// peso/pedo/pero; status phase, round, busy, done, rx_total, err_code,
// cycle_count.
module ring_gather_agent
    import ring_pkg::*;
#(
    parameter int NUM_NODES    = 4,
    parameter int NODE_ID      = 0,
    parameter int NUM_ROUNDS   = 8,
    parameter int PHASE_CYCLES = 10,
    parameter bit INJ_POLARITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        polarity,
    input  logic        start,
    input  logic        peri,
    output logic        pesi,
    output logic [63:0] pedi,
    output logic        pero,
    input  logic        peso,
    input  logic [63:0] pedo,
    output logic [3:0]  phase,
    output logic [7:0]  round,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_total,
    output logic [3:0]  err_code,
    output logic [31:0] cycle_count
);

    localparam logic [15:0] WIN_LAST   = 16'(PHASE_CYCLES - 1);
    localparam logic [3:0]  LAST_PHASE = 4'(NUM_NODES - 1);
    localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_phase;
    logic [7:0]  r_round;
    logic [15:0] r_win;
    logic        r_busy;
    logic        r_done;
    logic        r_built;
    logic [63:0] r_pedi;
    logic        r_err_to;
    logic [31:0] r_cycles;

    logic        w_is_root;
    logic        w_pesi;
    logic        w_fire;
    logic        w_start;
    logic        w_win_end;
    logic        w_last;
    logic [8:0]  w_route;
    logic [63:0] w_pkt;
    logic        w_pero;
    logic        w_miss;
    logic        w_unexp;
    logic        w_dup;

    assign w_is_root = (r_phase == 4'(NODE_ID));
    assign w_start   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_win_end = r_busy && (r_win == WIN_LAST);
    assign w_last    = (r_phase == LAST_PHASE) && (r_round == LAST_ROUND);
    assign w_route   = ring_route(4'(NODE_ID), r_phase, 5'(NUM_NODES));

    // pesi follows polarity combinationally so it is only offered in
    // matching-polarity cycles; gating with reset keeps it 0 at reset.
    assign w_pesi = (r_state == ST_INJECT) && r_built
                 && (polarity == INJ_POLARITY) && !reset;
    assign w_fire = w_pesi && peri;
    assign w_pero = !reset;

    always_comb begin
        w_pkt = '0;
        w_pkt[VC_BIT]          = INJ_POLARITY;
        w_pkt[DIR_BIT]         = w_route[8];
        w_pkt[HOP_MSB:HOP_LSB] = w_route[7:0];
        w_pkt[SRC_MSB:SRC_LSB] = 16'(NODE_ID);
        w_pkt[23:16]           = r_round;
        w_pkt[3:0]             = r_phase;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start)
                    w_state_nxt = ST_INJECT;
            end
            ST_INJECT: begin
                if (w_win_end)
                    w_state_nxt = w_last ? ST_DONE : ST_INJECT;
                else if (w_is_root || w_fire)
                    w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_win_end)
                    w_state_nxt = w_last ? ST_DONE : ST_INJECT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= '0;
            r_round  <= '0;
            r_win    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_built  <= 1'b0;
            r_pedi   <= '0;
            r_err_to <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_start) begin
                r_phase  <= '0;
                r_round  <= '0;
                r_win    <= '0;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
                r_built  <= 1'b0;
                r_err_to <= 1'b0;
            end else if (r_busy) begin
                if (w_win_end) begin
                    r_win   <= '0;
                    r_built <= 1'b0;
                    // A handshake landing on the last cycle still counts.
                    if ((r_state == ST_INJECT) && !w_fire)
                        r_err_to <= 1'b1;
                    if (r_phase == LAST_PHASE) begin
                        r_phase <= '0;
                        if (r_round == LAST_ROUND) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_round <= r_round + 8'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end else begin
                    r_win <= r_win + 16'd1;
                    if ((r_state == ST_INJECT) && !r_built && !w_is_root) begin
                        r_pedi  <= w_pkt;
                        r_built <= 1'b1;
                    end
                end
            end
        end
    end

    gather_rx_checker #(
        .NUM_NODES (NUM_NODES),
        .NODE_ID   (NODE_ID)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start),
        .i_phase_end (w_win_end),
        .i_busy      (r_busy),
        .i_phase     (r_phase),
        .i_round     (r_round),
        .i_valid     (peso && w_pero),
        .i_data      (pedo),
        .o_rx_total  (rx_total),
        .o_err_miss  (w_miss),
        .o_err_unexp (w_unexp),
        .o_err_dup   (w_dup)
    );

    always_comb begin
        err_code                 = '0;
        err_code[ERR_TX_TIMEOUT] = r_err_to;
        err_code[ERR_MISSING]    = w_miss;
        err_code[ERR_UNEXPECTED] = w_unexp;
        err_code[ERR_DUPLICATE]  = w_dup;
    end

    assign pesi        = w_pesi;
    assign pedi        = r_pedi;
    assign pero        = w_pero;
    assign phase       = r_phase;
    assign round       = r_round;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cycle_count = r_cycles;

endmodule

// File: tb/tb_ring_gather_agent.sv
// Scoreboard bench for ring_gather_agent: the bench plays the ring and
// the other nodes for two agents (node 2 polarity 0, node 1 polarity 1).
module tb_ring_gather_agent;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_pol   = 1'b0;
    logic        a_start = 1'b0;
    logic        a_peri  = 1'b0;
    logic        a_peso  = 1'b0;
    logic [63:0] a_pedo  = '0;
    logic        a_pesi, a_pero, a_busy, a_done;
    logic [63:0] a_pedi;
    logic [3:0]  a_phase, a_err;
    logic [7:0]  a_round;
    logic [15:0] a_rx;
    logic [31:0] a_cyc;

    logic        b_pol   = 1'b0;
    logic        b_tog   = 1'b0;
    logic        b_start = 1'b0;
    logic        b_peri  = 1'b0;
    logic        b_peso  = 1'b0;
    logic [63:0] b_pedo  = '0;
    logic        b_pesi, b_pero, b_busy, b_done;
    logic [63:0] b_pedi;
    logic [3:0]  b_phase, b_err;
    logic [7:0]  b_round;
    logic [15:0] b_rx;
    logic [31:0] b_cyc;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    ring_gather_agent #(
        .NUM_NODES(4), .NODE_ID(2), .NUM_ROUNDS(1),
        .PHASE_CYCLES(10), .INJ_POLARITY(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .polarity(a_pol), .start(a_start),
        .peri(a_peri), .pesi(a_pesi), .pedi(a_pedi), .pero(a_pero),
        .peso(a_peso), .pedo(a_pedo), .phase(a_phase), .round(a_round),
        .busy(a_busy), .done(a_done), .rx_total(a_rx), .err_code(a_err),
        .cycle_count(a_cyc)
    );

    ring_gather_agent #(
        .NUM_NODES(4), .NODE_ID(1), .NUM_ROUNDS(1),
        .PHASE_CYCLES(10), .INJ_POLARITY(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .polarity(b_pol), .start(b_start),
        .peri(b_peri), .pesi(b_pesi), .pedi(b_pedi), .pero(b_pero),
        .peso(b_peso), .pedo(b_pedo), .phase(b_phase), .round(b_round),
        .busy(b_busy), .done(b_done), .rx_total(b_rx), .err_code(b_err),
        .cycle_count(b_cyc)
    );

    always @(posedge clk) begin
        #1;
        b_pol = b_tog ? ~b_pol : 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    always @(negedge clk) begin
        if (!reset && a_pesi && a_peri) begin
            if (qa.size() == 0)
                fail_now("a_tx_extra", $sformatf("got %h, expected none", a_pedi));
            else
                check("a_tx_pkt", a_pedi, qa.pop_front());
        end
        if (!reset && b_pesi && b_peri) begin
            check("b_tx_pol", 64'(b_pol), 64'd1);
            if (qb.size() == 0)
                fail_now("b_tx_extra", $sformatf("got %h, expected none", b_pedi));
            else
                check("b_tx_pkt", b_pedi, qb.pop_front());
        end
    end

    function automatic logic [63:0] mk(input logic [15:0] src,
                                       input logic [3:0] ph,
                                       input logic [7:0] rd);
        return {16'h0, src, 8'h0, rd, 12'h0, ph};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        a_start = 1'b0; a_peri = 1'b0; a_peso = 1'b0; a_pedo = '0;
        b_start = 1'b0; b_peri = 1'b0; b_peso = 1'b0; b_pedo = '0;
        b_tog   = 1'b0;
        qa.delete();
        qb.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        @(posedge clk);
        #1;
        if (sel) b_start = 1'b1;
        else     a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic deliver(input bit sel, input logic [63:0] pkt);
        @(posedge clk);
        #1;
        if (sel) begin
            b_peso = 1'b1; b_pedo = pkt;
        end else begin
            a_peso = 1'b1; a_pedo = pkt;
        end
        @(posedge clk);
        #1;
        a_peso = 1'b0;
        b_peso = 1'b0;
    endtask

    task automatic wait_phase(input bit sel, input logic [3:0] p,
                              input string name);
        int k = 0;
        @(negedge clk);
        while (((sel ? b_phase : a_phase) != p) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200)
            fail_now(name, $sformatf("got phase %0d, expected %0d",
                                     sel ? b_phase : a_phase, p));
    endtask

    task automatic wait_done(input bit sel, input string name);
        int k = 0;
        @(negedge clk);
        while (!(sel ? b_done : a_done) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300)
            fail_now(name, "got done 0, expected 1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;

        // Reset state while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pesi",  64'(a_pesi),  64'd0);
        check("rst_pedi",  a_pedi,       64'd0);
        check("rst_pero",  64'(a_pero),  64'd0);
        check("rst_busy",  64'(a_busy),  64'd0);
        check("rst_done",  64'(a_done),  64'd0);
        check("rst_phase", 64'(a_phase), 64'd0);
        check("rst_rx",    64'(a_rx),    64'd0);
        check("rst_err",   64'(a_err),   64'd0);
        check("rst_cyc",   64'(a_cyc),   64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("pero_on", 64'(a_pero), 64'd1);

        // Full sweep on node 2: sends in phases 0, 1, 3; root in phase 2.
        a_peri = 1'b1;
        qa.push_back(64'h0003_0002_0000_0000);
        qa.push_back(64'h4001_0002_0000_0001);
        qa.push_back(64'h0001_0002_0000_0003);
        pulse_start(1'b0);
        @(negedge clk);
        check("a_busy_run", 64'(a_busy), 64'd1);
        wait_phase(1'b0, 4'd2, "a_wait_root");
        deliver(1'b0, mk(16'd0, 4'd2, 8'd0));
        deliver(1'b0, mk(16'd1, 4'd2, 8'd0));
        deliver(1'b0, mk(16'd3, 4'd2, 8'd0));
        wait_done(1'b0, "a_done_wait");
        check("a_full_err",  64'(a_err),      64'd0);
        check("a_full_rx",   64'(a_rx),       64'd3);
        check("a_full_busy", 64'(a_busy),     64'd0);
        check("a_full_q",    64'(qa.size()),  64'd0);

        // Duplicate and wrong-phase deliveries at the root.
        do_reset();
        a_peri = 1'b1;
        qa.push_back(64'h0003_0002_0000_0000);
        qa.push_back(64'h4001_0002_0000_0001);
        qa.push_back(64'h0001_0002_0000_0003);
        pulse_start(1'b0);
        wait_phase(1'b0, 4'd2, "a_wait_root2");
        deliver(1'b0, mk(16'd1, 4'd2, 8'd0));
        deliver(1'b0, mk(16'd1, 4'd2, 8'd0));
        @(negedge clk);
        check("dup_rx",  64'(a_rx),     64'd1);
        check("dup_err", 64'(a_err[3]), 64'd1);
        deliver(1'b0, mk(16'd3, 4'd1, 8'd0));
        @(negedge clk);
        check("unexp_err", 64'(a_err[2]), 64'd1);
        check("unexp_rx",  64'(a_rx),     64'd1);
        wait_done(1'b0, "a_done_wait2");
        check("bad_err_final", 64'(a_err),     64'hE);
        check("bad_q",         64'(qa.size()), 64'd0);

        // Ring never ready: timeout at the end of phase 0.
        do_reset();
        pulse_start(1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("to_pesi_w5", 64'(a_pesi), 64'd1);
        check("to_pedi_w5", a_pedi, 64'h0003_0002_0000_0000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("to_phase_w9", 64'(a_phase), 64'd0);
        check("to_err_w9",   64'(a_err),   64'd0);
        @(posedge clk);
        @(negedge clk);
        check("to_phase_next", 64'(a_phase), 64'd1);
        check("to_err",        64'(a_err),   64'd1);
        check("to_pesi_drop",  64'(a_pesi),  64'd0);

        // Reset in phase 2 aborts, then a rerun from phase 0.
        wait_phase(1'b0, 4'd2, "a_wait_abort");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ab_pesi",  64'(a_pesi),  64'd0);
        check("ab_pedi",  a_pedi,       64'd0);
        check("ab_busy",  64'(a_busy),  64'd0);
        check("ab_phase", 64'(a_phase), 64'd0);
        check("ab_err",   64'(a_err),   64'd0);
        check("ab_cyc",   64'(a_cyc),   64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        @(negedge clk);
        check("re_cyc",   64'(a_cyc),   64'd4);
        check("re_phase", 64'(a_phase), 64'd0);
        check("re_round", 64'(a_round), 64'd0);
        check("re_busy",  64'(a_busy),  64'd1);

        // Node 1 injecting on polarity 1 with polarity toggling.
        do_reset();
        b_peri = 1'b1;
        b_tog  = 1'b1;
        qb.push_back(64'hC001_0001_0000_0000);
        qb.push_back(64'h8001_0001_0000_0002);
        qb.push_back(64'h8003_0001_0000_0003);
        pulse_start(1'b1);
        first = -1;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (b_pesi && (first < 0))
                first = w;
            @(posedge clk);
        end
        check("b_first_win_ok", 64'((first == 1) || (first == 2)), 64'd1);
        wait_phase(1'b1, 4'd1, "b_wait_root");
        deliver(1'b1, mk(16'd0, 4'd1, 8'd0));
        deliver(1'b1, mk(16'd2, 4'd1, 8'd0));
        deliver(1'b1, mk(16'd3, 4'd1, 8'd0));
        wait_done(1'b1, "b_done_wait");
        check("b_err", 64'(b_err),     64'd0);
        check("b_rx",  64'(b_rx),      64'd3);
        check("b_q",   64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
